uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Shares one UART serializer among N_REQ byte producers, e.g. the calculator result path and the echo path.
- Picks one requester round-robin, captures its byte, then shifts one 8N1 frame onto txd.
- Advances exactly one bit per txen strobe from the baud enable generator; txen is one clk wide, once per bit period.
- Sits between the producers and the txd pin.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, bits per frame payload.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- txen  in  1  bit-period strobe, one clk wide
- req  in  N_REQ  per-requester transmit request, level
- data  in  N_REQ*DATA_W  flattened payloads; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot, one-cycle pulse: byte of requester i captured
- owner  out  3  index of requester owning the current or last frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of the stop bit
- txd  out  1  serial line, idle high

Behaviour:
- Reset, asynchronous: state=IDLE, txd=1, gnt=0, done=0, busy=0, owner=0, rr pointer last=N_REQ-1 so requester 0 has first priority.
- Reset mid-frame aborts the frame and forces txd=1 immediately.
- All outputs are registered.
- State IDLE, req!=0 at edge E:
  - Winner is the first set req bit searching upward from last+1, wrapping at N_REQ.
  - data[winner] is latched into the shift register at E.
  - last=winner and owner=winner are set at E.
  - gnt[winner]=1 for exactly the cycle after E.
  - state goes to WAIT.
- A txen coincident with capture edge E is ignored.
- Handshake: requester holds req and data stable until it sees gnt; it may drop req or present the next byte from the cycle after gnt. req is not sampled outside IDLE.
- Requester withdrawal: deasserting req before grant withdraws the request; no glitch on txd.
- Bit sequencing, transitions taken only on edges where txen=1:
  - WAIT -> START, txd=0.
  - START -> DATA, txd=d[0], bit counter=0.
  - DATA -> DATA while counter<DATA_W-1: shift, counter+1, txd=next bit, LSB first.
  - DATA with counter=DATA_W-1 -> STOP, txd=1 (or -> PARITY when the parity option is on).
  - STOP -> IDLE, done=1 for one cycle.
- Each bit is held exactly one txen period.
- Back-to-back frames: new capture occurs on the cycle after returning to IDLE, then WAIT for the next txen. The line therefore stays high for 2 bit periods between frames. This gap is required behaviour, not a defect.
- Counter is clog2(DATA_W) bits and wraps only through the DATA->STOP transition.
- txen high on consecutive clocks is legal: one bit per clock.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: after the last data bit the FSM enters PARITY with txd = even parity (XOR of the latched byte) for one txen period, then goes to STOP. Frame is 8E1, 11 bit periods.
- Undefined: no PARITY state exists, and a DATA -> STOP transition (8N1, 10 bit periods).
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, WAIT, START, DATA, PARITY, STOP
  - DATA_W default
  - IDLE_LVL=1 and START_LVL=0 constants
- Sub-module rr_arbiter (parameter N_REQ): combinational round-robin winner select from req and last. It outputs a one-hot grant and an index. Pointer update stays in uart_tx_sched.

Test Plan (txen every 16 clk):
- req[0]=1, data=0x55 -> gnt[0] pulse 1 cycle after capture. txd per bit period: 0,1,0,1,0,1,0,1,0,1. done pulses at the end of the stop bit; busy falls in the same cycle.
- req=2'b11 after reset with data0=0xA1, data1=0x3C, held -> frames sent in order 0xA1 (owner=0) then 0x3C (owner=1). Both req reasserted afterwards -> requester 0 granted next.
- Back-to-back on requester 1 -> txd high for exactly 32 clk between the stop-bit start and the next start bit.
- Reset pulsed during data bit 4 of 0xFF -> txd=1 and busy=0 at once. After release, req[1] alone -> full clean frame.
- txen coincident with the capture edge -> start bit begins on the following txen, not the coincident one.
- UART_PARITY_EN defined, byte 0x07 -> parity bit 1. Byte 0x03 -> parity bit 0. Frame is 11 periods and done is delayed by one period.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit scheduler.
// UART_PARITY_EN adds the PARITY state (8E1 frames); default build is 8N1.
package uart_pkg;

    localparam int   DEF_DATA_W = 8;
    localparam logic IDLE_LVL   = 1'b1;
    localparam logic START_LVL  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1.
// Outputs a one-hot grant and its index; the pointer itself lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [2:0]       idx,
    output logic             vld
);

    logic found;
    int   cand;

    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        // k = N_REQ revisits last itself, so a lone requester always wins
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt_oh[cand] = 1'b1;
                idx          = 3'(cand);
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shares one UART serializer among N_REQ producers; one bit per txen strobe.
// 8N1 by default; defining UART_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    txen,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic [2:0]              owner,
    output logic                    busy,
    output logic                    done,
    output logic                    txd
);

    localparam int         CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [2:0] LAST_RST = 3'(N_REQ - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          last_q, last_d;
    logic [2:0]          owner_q, owner_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                txd_q, txd_d;
`ifdef UART_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [N_REQ-1:0]    arb_gnt;
    logic [2:0]          arb_idx;
    logic                arb_vld;
    logic [DATA_W-1:0]   win_dat;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .gnt_oh (arb_gnt),
        .idx    (arb_idx),
        .vld    (arb_vld)
    );

    always_comb begin
        win_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_dat = win_dat | (data[i*DATA_W +: DATA_W] & {DATA_W{arb_gnt[i]}});
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        txd_d   = txd_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            // txen is deliberately ignored here: the start bit waits for the next strobe
            IDLE: begin
                if (arb_vld) begin
                    shreg_d = win_dat;
                    last_d  = arb_idx;
                    owner_d = arb_idx;
                    gnt_d   = arb_gnt;
                    state_d = WAIT;
`ifdef UART_PARITY_EN
                    par_d   = ^win_dat;
`endif
                end
            end
            WAIT: begin
                if (txen) begin
                    state_d = START;
                    txd_d   = START_LVL;
                end
            end
            START: begin
                if (txen) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (txen) begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = IDLE_LVL;
`endif
                    end else begin
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        txd_d   = shreg_d[0];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (txen) begin
                    state_d = STOP;
                    txd_d   = IDLE_LVL;
                end
            end
`endif
            STOP: begin
                if (txen) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = IDLE_LVL;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            txd_q   <= IDLE_LVL;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            txd_q   <= txd_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign txd   = txd_q;

endmodule
